// File: rtl/icache_if.sv
// icache_if: bundles the fetch-side handshake and the memory-controller refill
// port of the instruction cache.
//   fetch_en / fetch_pc    : fetch request from the instruction-fetch unit
//   inst_valid / inst      : one-cycle instruction return to the fetch unit
//   if_en / if_pc          : line refill request to the memory controller
//   if_done / if_data      : refill completion pulse and returned line
// Modport slave is the cache; modport master is the fetch unit plus memory
// controller side.
interface icache_if #(
  parameter int LINE_BYTES = 16
);
  logic                    fetch_en;
  logic [31:0]             fetch_pc;
  logic                    inst_valid;
  logic [31:0]             inst;
  logic                    if_en;
  logic [31:0]             if_pc;
  logic                    if_done;
  logic [8*LINE_BYTES-1:0] if_data;

  modport slave (
    input  fetch_en, fetch_pc, if_done, if_data,
    output inst_valid, inst, if_en, if_pc
  );

  modport master (
    output fetch_en, fetch_pc, if_done, if_data,
    input  inst_valid, inst, if_en, if_pc
  );
endinterface

// File: rtl/icache.sv
// icache: direct-mapped, read-only instruction cache.
// A fetch PC is looked up in one cycle while IDLE. A hit returns the word on the
// next cycle; a miss raises a line-aligned refill request and waits in MISS for
// the memory controller's if_done, then writes the line and returns the word.
// A rollback during a refill only suppresses the instruction return; the
// refill itself always completes and the line is still written.
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset
//   rdy      : global ready, 0 freezes all state (inst_valid forced low)
//   rollback : pipeline flush
//   bus      : icache_if.slave (fetch request/return and refill port)
module icache #(
  parameter int LINE_BYTES = 16,
  parameter int SETS       = 16
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     rdy,
  input  logic     rollback,
  icache_if.slave  bus
);

  localparam int OFF    = $clog2(LINE_BYTES);
  localparam int IDX    = $clog2(SETS);
  localparam int TAGW   = 32 - OFF - IDX;
  localparam int WORDS  = LINE_BYTES / 4;
  localparam int LINE_W = 8 * LINE_BYTES;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MISS = 1'b1
  } state_t;

  // Little-endian word pc[OFF-1:2] of a line (bytes 4w..4w+3).
  function automatic logic [31:0] word_sel(input logic [LINE_W-1:0] line,
                                           input logic [31:0]       pc);
    logic [31:0] widx;
    widx = {2'b00, pc[31:2]} & 32'(WORDS - 1);
    return line[widx * 32'd32 +: 32];
  endfunction

  // Line-aligned refill address.
  function automatic logic [31:0] line_addr(input logic [31:0] pc);
    return {pc[31:OFF], {OFF{1'b0}}};
  endfunction

  // Storage arrays
  logic [SETS-1:0]   valid_r;
  logic [TAGW-1:0]   tag_r  [SETS];
  logic [LINE_W-1:0] data_r [SETS];

  // State and registered outputs
  state_t      state_r, state_nx;
  logic        inst_valid_r, inst_valid_nx;
  logic [31:0] inst_r, inst_nx;
  logic        if_en_r, if_en_nx;
  logic [31:0] if_pc_r, if_pc_nx;
  logic        discard_r, discard_nx;
  logic [31:0] pc_r, pc_nx;
  logic        fill_we_s;

  // Lookup path on the incoming fetch PC
  logic [IDX-1:0]  look_idx_s;
  logic [TAGW-1:0] look_tag_s;
  logic            hit_s;
  logic [IDX-1:0]  fill_idx_s;

  assign look_idx_s = bus.fetch_pc[OFF+IDX-1:OFF];
  assign look_tag_s = bus.fetch_pc[31:OFF+IDX];
  assign hit_s      = valid_r[look_idx_s] && (tag_r[look_idx_s] == look_tag_s);
  assign fill_idx_s = pc_r[OFF+IDX-1:OFF];

  assign bus.inst_valid = inst_valid_r;
  assign bus.inst       = inst_r;
  assign bus.if_en      = if_en_r;
  assign bus.if_pc      = if_pc_r;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next-state, next-output and refill-write decode
  always_comb begin
    state_nx      = state_r;
    inst_valid_nx = 1'b0;
    inst_nx       = inst_r;
    if_en_nx      = if_en_r;
    if_pc_nx      = if_pc_r;
    discard_nx    = discard_r;
    pc_nx         = pc_r;
    fill_we_s     = 1'b0;
    if (!rdy) begin
      // Frozen: everything holds, only the return pulse is suppressed.
      inst_valid_nx = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.fetch_en && !rollback) begin
            pc_nx = bus.fetch_pc;
            if (hit_s) begin
              inst_valid_nx = 1'b1;
              inst_nx       = word_sel(data_r[look_idx_s], bus.fetch_pc);
            end else begin
              if_en_nx   = 1'b1;
              if_pc_nx   = line_addr(bus.fetch_pc);
              discard_nx = 1'b0;
              state_nx   = MISS;
            end
          end else begin
            inst_valid_nx = 1'b0;
          end
        end
        MISS: begin
          if (rollback) begin
            discard_nx = 1'b1;
          end else begin
            discard_nx = discard_r;
          end
          if (bus.if_done) begin
            // The line is written even when the return is discarded.
            fill_we_s = 1'b1;
            if_en_nx  = 1'b0;
            state_nx  = IDLE;
            if (!discard_r && !rollback) begin
              inst_valid_nx = 1'b1;
              inst_nx       = word_sel(bus.if_data, pc_r);
            end else begin
              inst_valid_nx = 1'b0;
            end
          end else begin
            fill_we_s = 1'b0;
          end
        end
        default: begin
          state_nx = IDLE;
          if_en_nx = 1'b0;
        end
      endcase
    end
  end

  // Registered outputs and request context
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_valid_r <= 1'b0;
      inst_r       <= 32'h0000_0000;
      if_en_r      <= 1'b0;
      if_pc_r      <= 32'h0000_0000;
      discard_r    <= 1'b0;
      pc_r         <= 32'h0000_0000;
    end else begin
      inst_valid_r <= inst_valid_nx;
      inst_r       <= inst_nx;
      if_en_r      <= if_en_nx;
      if_pc_r      <= if_pc_nx;
      discard_r    <= discard_nx;
      pc_r         <= pc_nx;
    end
  end

  // Valid bits: cleared only by reset, set by a completed refill
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r <= '0;
    end else if (fill_we_s) begin
      valid_r[fill_idx_s] <= 1'b1;
    end
  end

  // Tag and data arrays: a refill overwrites the set unconditionally
  always_ff @(posedge clk) begin
    if (fill_we_s) begin
      tag_r[fill_idx_s]  <= pc_r[31:OFF+IDX];
      data_r[fill_idx_s] <= bus.if_data;
    end
  end

endmodule

// File: tb/tb_icache.sv
// tb_icache: self-checking bench for icache (LINE_BYTES=16, SETS=16).
// A reference tag model predicts hit/miss; expected instructions are queued
// when a request is driven and popped by a monitor on every inst_valid.
module tb_icache;

  localparam int LB = 16;
  localparam int NS = 16;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  logic rollback;

  icache_if #(.LINE_BYTES(LB)) bus ();

  icache #(.LINE_BYTES(LB), .SETS(NS)) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .rollback (rollback),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int          n_total = 0;
  int          n_bad   = 0;
  logic [31:0] exp_q[$];
  logic        m_valid[NS];
  logic [23:0] m_tag[NS];

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory content: byte i of the line at address a
  function automatic logic [7:0] mem_byte(input logic [31:0] a, input int i);
    logic [31:0] v;
    v = 32'(i) + 32'd37 * {20'd0, a[15:4]};
    return v[7:0];
  endfunction

  function automatic logic [8*LB-1:0] line_data(input logic [31:0] a);
    logic [8*LB-1:0] d;
    d = '0;
    for (int i = 0; i < LB; i++) d[8*i +: 8] = mem_byte(a, i);
    return d;
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] pc);
    logic [31:0] ln;
    logic [31:0] r;
    int          w;
    ln = {pc[31:4], 4'h0};
    w  = int'(pc[3:2]);
    r  = '0;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = mem_byte(ln, 4*w + k);
    return r;
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    return m_valid[pc[7:4]] && (m_tag[pc[7:4]] == pc[31:8]);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NS; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 24'h0;
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Scoreboard monitor: every returned instruction must be expected
  always @(negedge clk) begin
    if (rst && bus.inst_valid) begin
      if (exp_q.size() == 0) chk_val("spur_iv", 32'(bus.inst_valid), 32'd0);
      else chk_val("inst", bus.inst, exp_q.pop_front());
    end
  end

  // One fetch; refill answered after lat wait cycles, optional rollback on
  // wait cycle rb_at and a 5-cycle rdy stall before wait cycle stall_at.
  task automatic do_fetch(input logic [31:0] pc, input int lat, input int rb_at, input int stall_at);
    logic [31:0] ln;
    bit          hit;
    bit          rb;
    ln  = {pc[31:4], 4'h0};
    hit = model_hit(pc);
    rb  = 1'b0;
    bus.fetch_en = 1'b1;
    bus.fetch_pc = pc;
    if (hit) exp_q.push_back(exp_word(pc));
    step();
    bus.fetch_en = 1'b0;
    if (hit) begin
      chk_val("hit_iv", 32'(bus.inst_valid), 32'd1);
      chk_val("hit_if_en", 32'(bus.if_en), 32'd0);
    end else begin
      chk_val("miss_if_en", 32'(bus.if_en), 32'd1);
      chk_val("miss_if_pc", bus.if_pc, ln);
      chk_val("miss_iv", 32'(bus.inst_valid), 32'd0);
      for (int c = 1; c <= lat; c++) begin
        if (c == stall_at) begin
          rdy = 1'b0;
          for (int s = 0; s < 5; s++) begin
            step();
            chk_val("stall_if_en", 32'(bus.if_en), 32'd1);
            chk_val("stall_if_pc", bus.if_pc, ln);
            chk_val("stall_iv", 32'(bus.inst_valid), 32'd0);
          end
          rdy = 1'b1;
        end
        rollback = (c == rb_at);
        if (rollback) rb = 1'b1;
        if (c == lat) begin
          bus.if_done = 1'b1;
          bus.if_data = line_data(ln);
          if (!rb) exp_q.push_back(exp_word(pc));
        end
        step();
        rollback = 1'b0;
        if (c < lat) begin
          chk_val("wait_if_en", 32'(bus.if_en), 32'd1);
          chk_val("wait_if_pc", bus.if_pc, ln);
          chk_val("wait_iv", 32'(bus.inst_valid), 32'd0);
        end
      end
      bus.if_done = 1'b0;
      chk_val("done_if_en", 32'(bus.if_en), 32'd0);
      chk_val("done_iv", 32'(bus.inst_valid), rb ? 32'd0 : 32'd1);
      m_valid[pc[7:4]] = 1'b1;
      m_tag[pc[7:4]]   = pc[31:8];
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b0;
    rdy          = 1'b1;
    rollback     = 1'b0;
    bus.fetch_en = 1'b0;
    bus.fetch_pc = 32'h0;
    bus.if_done  = 1'b0;
    bus.if_data  = '0;
    model_clear();
    #23;
    chk_val("rst_iv", 32'(bus.inst_valid), 32'd0);
    chk_val("rst_inst", bus.inst, 32'h0);
    chk_val("rst_if_en", 32'(bus.if_en), 32'd0);
    chk_val("rst_if_pc", bus.if_pc, 32'h0);
    step();
    rst = 1'b1;
    step();

    // Cold miss
    do_fetch(32'h0000_1008, 2, 0, 0);
    chk_val("cold_inst", bus.inst, 32'h0B0A_0908);

    // Back-to-back hits
    bus.fetch_en = 1'b1;
    bus.fetch_pc = 32'h0000_1004;
    exp_q.push_back(exp_word(32'h0000_1004));
    step();
    chk_val("b2b_iv0", 32'(bus.inst_valid), 32'd1);
    chk_val("b2b_inst0", bus.inst, 32'h0706_0504);
    bus.fetch_pc = 32'h0000_100C;
    exp_q.push_back(exp_word(32'h0000_100C));
    step();
    chk_val("b2b_iv1", 32'(bus.inst_valid), 32'd1);
    chk_val("b2b_inst1", bus.inst, 32'h0F0E_0D0C);
    chk_val("b2b_if_en", 32'(bus.if_en), 32'd0);
    bus.fetch_en = 1'b0;
    step();
    chk_val("b2b_idle_iv", 32'(bus.inst_valid), 32'd0);

    // Conflict: same set, different tag, then the old line misses again
    do_fetch(32'h0000_1100, 3, 0, 0);
    do_fetch(32'h0000_1000, 1, 0, 0);

    // Rollback during miss, then the same PC hits
    do_fetch(32'h0000_1234, 5, 3, 0);
    do_fetch(32'h0000_1234, 1, 0, 0);
    // Rollback together with if_done
    do_fetch(32'h0000_1248, 2, 2, 0);
    do_fetch(32'h0000_1248, 1, 0, 0);

    // Rollback with a hit lookup: request ignored
    bus.fetch_en = 1'b1;
    bus.fetch_pc = 32'h0000_1004;
    rollback     = 1'b1;
    step();
    rollback     = 1'b0;
    bus.fetch_en = 1'b0;
    chk_val("rb_hit_iv", 32'(bus.inst_valid), 32'd0);

    // rdy stall during a miss and during a hit request
    do_fetch(32'h0000_1308, 3, 0, 2);
    bus.fetch_en = 1'b1;
    bus.fetch_pc = 32'h0000_1300;
    rdy          = 1'b0;
    for (int s = 0; s < 5; s++) begin
      step();
      chk_val("hstall_iv", 32'(bus.inst_valid), 32'd0);
    end
    rdy = 1'b1;
    exp_q.push_back(exp_word(32'h0000_1300));
    step();
    bus.fetch_en = 1'b0;
    chk_val("hstall_resume_iv", 32'(bus.inst_valid), 32'd1);
    chk_val("hstall_if_en", 32'(bus.if_en), 32'd0);

    // Random mix of hits, misses, conflicts and rollbacks
    for (int n = 0; n < 24; n++) begin
      logic [31:0] pc;
      int          lat;
      int          rb;
      pc  = 32'h0000_1000 + (32'($urandom_range(0, 7)) << 8)
          + (32'($urandom_range(0, 3)) << 4) + (32'($urandom_range(0, 3)) << 2);
      lat = int'($urandom_range(1, 4));
      rb  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, lat)) : 0;
      do_fetch(pc, lat, rb, 0);
    end

    // Async reset mid-MISS
    bus.fetch_en = 1'b1;
    bus.fetch_pc = 32'h0000_2000;
    step();
    bus.fetch_en = 1'b0;
    chk_val("ar_if_en_pre", 32'(bus.if_en), 32'd1);
    step();
    #2;
    rst = 1'b0;
    #1;
    chk_val("ar_if_en", 32'(bus.if_en), 32'd0);
    chk_val("ar_iv", 32'(bus.inst_valid), 32'd0);
    chk_val("ar_if_pc", bus.if_pc, 32'h0);
    model_clear();
    step();
    rst = 1'b1;
    // Late if_done in IDLE is ignored
    bus.if_done = 1'b1;
    bus.if_data = line_data(32'h0000_2000);
    step();
    bus.if_done = 1'b0;
    chk_val("late_done_if_en", 32'(bus.if_en), 32'd0);
    chk_val("late_done_iv", 32'(bus.inst_valid), 32'd0);
    do_fetch(32'h0000_2000, 2, 0, 0);
    do_fetch(32'h0000_1004, 1, 0, 0);
    do_fetch(32'h0000_2004, 1, 0, 0);

    step();
    chk_val("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
